// File: rtl/sa_seq_ctrl.sv
// Run-sequencer for the systolic-array top: fetches H weight rows, then H
// activation rows, from a 1-cycle-latency source memory and drives every
// buffer enable the top needs for one complete matrix pass per start pulse.
//
// Handshake: start is a level-sampled request that is only honoured while the
// sequencer is IDLE; there is no back-pressure. src_rd_en/src_addr form a
// fire-and-forget read whose data is valid on src_rdata exactly one cycle later.
module sa_seq_ctrl #(
  parameter int DATASIZE    = 8,
  parameter int ARRAYWIDTH  = 4,
  parameter int ARRAYHEIGHT = 4,
  parameter int DSP_DELAY   = 1,
  parameter int AW          = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [AW-1:0]                  w_base,
  input  logic [AW-1:0]                  a_base,
  output logic                           src_rd_en,
  output logic [AW-1:0]                  src_addr,
  input  logic [DATASIZE*ARRAYWIDTH-1:0] src_rdata,
  output logic [DATASIZE*ARRAYWIDTH-1:0] in_weight,
  output logic [DATASIZE*ARRAYWIDTH-1:0] in_act,
  output logic                           weight_buffer_load_en,
  output logic                           write_weight_en,
  output logic                           weight_buffer_out_en,
  output logic                           input_buffer_load_en,
  output logic                           input_buffer_out_en,
  output logic                           output_buffer_load_en,
  output logic                           output_buffer_out_en,
  output logic                           busy,
  output logic                           done,
  output logic [2:0]                     dbg_state
);

  localparam int H           = ARRAYHEIGHT;
  localparam int W           = ARRAYWIDTH;
  localparam int D           = DSP_DELAY;
  localparam int CW          = $clog2(2 * D * H + 1);
  localparam int LEN_COMPUTE = D * (W - 1);
  localparam int LEN_CAPTURE = 2 * D * H;
  localparam int H_LAST      = H - 1;
  localparam int CMP_LAST    = (LEN_COMPUTE > 0) ? LEN_COMPUTE - 1 : 0;
  localparam int CAP_LAST    = LEN_CAPTURE - 1;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_PREFETCH = 3'd1;
  localparam logic [2:0] S_LOAD_W   = 3'd2;
  localparam logic [2:0] S_LOAD_A   = 3'd3;
  localparam logic [2:0] S_COMPUTE  = 3'd4;
  localparam logic [2:0] S_CAPTURE  = 3'd5;
  localparam logic [2:0] S_DRAIN    = 3'd6;
  localparam logic [2:0] S_DONE     = 3'd7;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] w_base_q, w_base_d;
  logic [AW-1:0] a_base_q, a_base_d;

  logic h_last, cmp_last, cap_last;

  assign h_last   = (cnt_q == CW'(H_LAST));
  assign cmp_last = (cnt_q == CW'(CMP_LAST));
  assign cap_last = (cnt_q == CW'(CAP_LAST));

  // Next-state logic: the phase counter counts cycles inside a state and
  // reloads to zero whenever the state changes.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CW'(1);
    w_base_d = w_base_q;
    a_base_d = a_base_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) begin
          state_d  = S_PREFETCH;
          w_base_d = w_base;
          a_base_d = a_base;
        end
      end
      S_PREFETCH: begin
        state_d = S_LOAD_W;
        cnt_d   = '0;
      end
      S_LOAD_W: begin
        if (h_last) begin
          state_d = S_LOAD_A;
          cnt_d   = '0;
        end
      end
      S_LOAD_A: begin
        if (h_last) begin
          // A single-column array has no skew to wait out.
          state_d = (LEN_COMPUTE == 0) ? S_CAPTURE : S_COMPUTE;
          cnt_d   = '0;
        end
      end
      S_COMPUTE: begin
        if (cmp_last) begin
          state_d = S_CAPTURE;
          cnt_d   = '0;
        end
      end
      S_CAPTURE: begin
        if (cap_last) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end
      end
      S_DRAIN: begin
        if (h_last) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, phase counter and latched base addresses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      w_base_q <= '0;
      a_base_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      w_base_q <= w_base_d;
      a_base_q <= a_base_d;
    end
  end

  // Output decode from registered state/counter only, so start never reaches
  // an output combinationally. Reads run one row ahead of the data: the read
  // in the last LOAD_W cycle fetches the first activation row.
  always_comb begin
    src_rd_en             = 1'b0;
    src_addr              = '0;
    in_weight             = '0;
    in_act                = '0;
    weight_buffer_load_en = 1'b0;
    write_weight_en       = 1'b0;
    weight_buffer_out_en  = 1'b0;
    input_buffer_load_en  = 1'b0;
    input_buffer_out_en   = 1'b0;
    output_buffer_load_en = 1'b0;
    output_buffer_out_en  = 1'b0;
    case (state_q)
      S_PREFETCH: begin
        src_rd_en = 1'b1;
        src_addr  = w_base_q;
      end
      S_LOAD_W: begin
        src_rd_en             = 1'b1;
        src_addr              = h_last ? a_base_q : (w_base_q + AW'(cnt_q) + AW'(1));
        in_weight             = src_rdata;
        weight_buffer_load_en = 1'b1;
      end
      S_LOAD_A: begin
        src_rd_en            = !h_last;
        src_addr             = h_last ? '0 : (a_base_q + AW'(cnt_q) + AW'(1));
        in_act               = src_rdata;
        input_buffer_load_en = 1'b1;
        write_weight_en      = 1'b1;
        weight_buffer_out_en = 1'b1;
      end
      S_COMPUTE: begin
        input_buffer_out_en = 1'b1;
      end
      S_CAPTURE: begin
        input_buffer_out_en   = 1'b1;
        output_buffer_load_en = 1'b1;
      end
      S_DRAIN: begin
        input_buffer_out_en  = 1'b1;
        output_buffer_out_en = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign dbg_state = state_q;

endmodule
